// File: rtl/vlan_pcp_tdest_classifier_if.sv
// AXI-Stream bundle used on both sides of vlan_pcp_tdest_classifier.
//   tdata/tkeep/tvalid/tready/tlast/tuser : standard AXI-Stream beat signals
//   tdest                                : queue index, only meaningful on the master side
// master drives a stream (and its tdest), slave consumes one (tdest is not part of it).
interface vlan_pcp_tdest_classifier_if #(
    parameter int unsigned DATA_BYTES  = 1,
    parameter int unsigned TDEST_WIDTH = 3
);
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [1:0]              tuser;
    logic [TDEST_WIDTH-1:0]  tdest;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser, tdest,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/vlan_pcp_tdest_classifier.sv
// VLAN PCP to tdest classifier.
// Buffers the first HDR_BEATS beats of each frame, decodes a single 802.1Q tag or a stacked
// 802.1ad/QinQ tag pair, maps the selected PCP through pcp_map and presents the result as a
// registered m_axis.tdest held for the whole frame. The buffered beats are then replayed and
// the rest of the frame is passed straight through.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   pcp_map        : entry i (bits [i*TDEST_WIDTH +: TDEST_WIDTH]) is the queue for PCP i
//   default_dest   : queue for untagged or short frames
//   s_axis         : input stream (slave modport), tuser passed through unchanged
//   m_axis         : output stream (master modport) including tdest
//   cnt_tagged     : frames classified as single-tagged (wraps)
//   cnt_qinq       : frames classified as stacked-tag (wraps)
//   cnt_untagged   : frames classified as untagged or short (wraps)
// HDR_BYTES must be at least 19 so that every byte the decision looks at lies in the buffer.
module vlan_pcp_tdest_classifier #(
    parameter int unsigned DATA_BYTES    = 1,
    parameter int unsigned TDEST_WIDTH   = 3,
    parameter bit          SUPPORT_QINQ  = 1'b1,
    parameter bit          USE_INNER_PCP = 1'b1,
    parameter int unsigned HDR_BYTES     = 20
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [8*TDEST_WIDTH-1:0]   pcp_map,
    input  logic [TDEST_WIDTH-1:0]     default_dest,
    vlan_pcp_tdest_classifier_if.slave  s_axis,
    vlan_pcp_tdest_classifier_if.master m_axis,
    output logic [31:0]                cnt_tagged,
    output logic [31:0]                cnt_qinq,
    output logic [31:0]                cnt_untagged
);

    localparam int unsigned DW        = 8 * DATA_BYTES;
    localparam int unsigned HDR_BEATS = (HDR_BYTES + DATA_BYTES - 1) / DATA_BYTES;
    localparam int unsigned IDX_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

    localparam logic [1:0] StBuffer = 2'd0;
    localparam logic [1:0] StFlush  = 2'd1;
    localparam logic [1:0] StPass   = 2'd2;

    localparam logic [1:0] KindUntagged = 2'd0;
    localparam logic [1:0] KindTagged   = 2'd1;
    localparam logic [1:0] KindQinq     = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       in_idx_q, in_idx_d;
    logic [IDX_W-1:0]       out_idx_q, out_idx_d;
    logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
    logic [31:0]            cnt_tagged_q, cnt_qinq_q, cnt_untagged_q;
    logic                   inc_tagged, inc_qinq, inc_untagged;

    // Header buffer, deliberately not reset.
    logic [DW-1:0]          hdr_data [HDR_BEATS];
    logic [DATA_BYTES-1:0]  hdr_keep [HDR_BEATS];
    logic                   hdr_last [HDR_BEATS];
    logic [1:0]             hdr_user [HDR_BEATS];

    // Returns {valid, byte} for a frame byte offset, looking at the stored beats and the beat
    // currently being accepted. Beats beyond the current one do not exist yet.
    function automatic logic [8:0] hdr_byte(input int unsigned off);
        int unsigned           beat;
        int unsigned           lane;
        logic [DATA_BYTES-1:0] kb;
        logic [7:0]            db;
        logic [8:0]            r;
        beat = off / DATA_BYTES;
        lane = off % DATA_BYTES;
        r    = '0;
        if (beat < HDR_BEATS) begin
            if (IDX_W'(beat) < in_idx_q) begin
                kb = hdr_keep[IDX_W'(beat)] >> lane;
                db = 8'(hdr_data[IDX_W'(beat)] >> (8 * lane));
                r  = {kb[0], db};
            end else if (IDX_W'(beat) == in_idx_q) begin
                kb = s_axis.tkeep >> lane;
                db = 8'(s_axis.tdata >> (8 * lane));
                r  = {kb[0], db};
            end
        end
        return r;
    endfunction

    logic [8:0]             b12, b13, b14, b16, b17, b18;
    logic [15:0]            outer_et, inner_et;
    logic                   outer_ok, is_ctag, is_stag, inner_ok;
    logic [2:0]             dec_pcp;
    logic [1:0]             dec_kind;
    logic [TDEST_WIDTH-1:0] dec_dest;
    logic                   hdr_done;

    always_comb begin
        b12 = hdr_byte(12);
        b13 = hdr_byte(13);
        b14 = hdr_byte(14);
        b16 = hdr_byte(16);
        b17 = hdr_byte(17);
        b18 = hdr_byte(18);

        outer_et = {b12[7:0], b13[7:0]};
        inner_et = {b16[7:0], b17[7:0]};
        // A tag is only usable if its TCI byte (14) has arrived as well.
        outer_ok = b12[8] && b13[8] && b14[8];
        is_ctag  = outer_ok && (outer_et == 16'h8100);
        is_stag  = SUPPORT_QINQ && outer_ok &&
                   ((outer_et == 16'h88A8) || (outer_et == 16'h9100));
        inner_ok = b16[8] && b17[8] && b18[8] && (inner_et == 16'h8100);

        dec_kind = KindUntagged;
        dec_pcp  = '0;
        if (is_stag && inner_ok) begin
            dec_kind = KindQinq;
            dec_pcp  = USE_INNER_PCP ? b18[7:5] : b14[7:5];
        end else if (is_ctag || is_stag) begin
            // An outer tag without a valid inner tag degrades to a single tag.
            dec_kind = KindTagged;
            dec_pcp  = b14[7:5];
        end

        dec_dest = default_dest;
        if (dec_kind != KindUntagged) begin
            dec_dest = TDEST_WIDTH'(pcp_map >> (dec_pcp * TDEST_WIDTH));
        end

        hdr_done = (in_idx_q == IDX_W'(HDR_BEATS - 1)) || s_axis.tlast;
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        in_idx_d     = in_idx_q;
        out_idx_d    = out_idx_q;
        tdest_d      = tdest_q;
        inc_tagged   = 1'b0;
        inc_qinq     = 1'b0;
        inc_untagged = 1'b0;
        case (state_q)
            StBuffer: begin
                if (s_axis.tvalid) begin
                    if (hdr_done) begin
                        // in_idx stays on the last stored beat; FLUSH uses it as its end mark.
                        state_d   = StFlush;
                        out_idx_d = '0;
                        tdest_d   = dec_dest;
                        case (dec_kind)
                            KindQinq:   inc_qinq     = 1'b1;
                            KindTagged: inc_tagged   = 1'b1;
                            default:    inc_untagged = 1'b1;
                        endcase
                    end else begin
                        in_idx_d = in_idx_q + IDX_W'(1);
                    end
                end
            end
            StFlush: begin
                if (m_axis.tready) begin
                    if (out_idx_q == in_idx_q) begin
                        state_d   = hdr_last[out_idx_q] ? StBuffer : StPass;
                        in_idx_d  = '0;
                        out_idx_d = '0;
                    end else begin
                        out_idx_d = out_idx_q + IDX_W'(1);
                    end
                end
            end
            StPass: begin
                if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
                    state_d = StBuffer;
                end
            end
            default: state_d = StBuffer;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= StBuffer;
            in_idx_q       <= '0;
            out_idx_q      <= '0;
            tdest_q        <= '0;
            cnt_tagged_q   <= '0;
            cnt_qinq_q     <= '0;
            cnt_untagged_q <= '0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            tdest_q   <= tdest_d;
            if (inc_tagged)   cnt_tagged_q   <= cnt_tagged_q + 32'd1;
            if (inc_qinq)     cnt_qinq_q     <= cnt_qinq_q + 32'd1;
            if (inc_untagged) cnt_untagged_q <= cnt_untagged_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StBuffer && s_axis.tvalid) begin
            hdr_data[in_idx_q] <= s_axis.tdata;
            hdr_keep[in_idx_q] <= s_axis.tkeep;
            hdr_last[in_idx_q] <= s_axis.tlast;
            hdr_user[in_idx_q] <= s_axis.tuser;
        end
    end

    // Output steering: replay from the buffer in FLUSH, wire through in PASS.
    always_comb begin
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = hdr_data[out_idx_q];
        m_axis.tkeep  = hdr_keep[out_idx_q];
        m_axis.tlast  = hdr_last[out_idx_q];
        m_axis.tuser  = hdr_user[out_idx_q];
        case (state_q)
            StBuffer: s_axis.tready = 1'b1;
            StFlush:  m_axis.tvalid = 1'b1;
            StPass: begin
                s_axis.tready = m_axis.tready;
                m_axis.tvalid = s_axis.tvalid;
                m_axis.tdata  = s_axis.tdata;
                m_axis.tkeep  = s_axis.tkeep;
                m_axis.tlast  = s_axis.tlast;
                m_axis.tuser  = s_axis.tuser;
            end
            default: ;
        endcase
    end

    assign m_axis.tdest = tdest_q;
    assign cnt_tagged   = cnt_tagged_q;
    assign cnt_qinq     = cnt_qinq_q;
    assign cnt_untagged = cnt_untagged_q;

endmodule

// File: tb/tb_vlan_pcp_tdest_classifier.sv
// Self-checking bench for vlan_pcp_tdest_classifier (4-byte beats, QinQ on, inner PCP).
// Frames are modelled as plain byte lists; the expected class, queue and counters are derived
// from the byte offsets of the frame, and expected output beats go through a scoreboard queue.
module tb_vlan_pcp_tdest_classifier;

    localparam int unsigned DB = 4;
    localparam int unsigned TW = 3;

    typedef struct packed {
        logic [8*DB-1:0] data;
        logic [DB-1:0]   keep;
        logic            last;
        logic [1:0]      user;
        logic [TW-1:0]   dest;
    } beat_t;

    logic            clk;
    logic            rstn;
    logic [8*TW-1:0] pcp_map;
    logic [TW-1:0]   default_dest;
    logic [31:0]     cnt_tagged, cnt_qinq, cnt_untagged;

    vlan_pcp_tdest_classifier_if #(.DATA_BYTES(DB), .TDEST_WIDTH(TW)) s_if ();
    vlan_pcp_tdest_classifier_if #(.DATA_BYTES(DB), .TDEST_WIDTH(TW)) m_if ();

    vlan_pcp_tdest_classifier #(
        .DATA_BYTES    (DB),
        .TDEST_WIDTH   (TW),
        .SUPPORT_QINQ  (1'b1),
        .USE_INNER_PCP (1'b1),
        .HDR_BYTES     (20)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pcp_map      (pcp_map),
        .default_dest (default_dest),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .cnt_tagged   (cnt_tagged),
        .cnt_qinq     (cnt_qinq),
        .cnt_untagged (cnt_untagged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [TW-1:0] map_m [8];
    logic [TW-1:0] dflt_m;
    int unsigned   n_tag_m, n_qinq_m, n_untag_m;
    beat_t         exp_q [$];
    logic [7:0]    frm [$];
    int            n_checks, n_errors;
    int            rdy_mode;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_map();
        logic [8*TW-1:0] v;
        v = '0;
        for (int i = 7; i >= 0; i--) v = (v << TW) | (8*TW)'(map_m[i]);
        pcp_map      = v;
        default_dest = dflt_m;
    endtask

    task automatic make_frame(input int len, input logic [15:0] et, input logic [7:0] tci,
                              input logic [15:0] et2, input logic [7:0] tci2);
        frm.delete();
        for (int i = 0; i < len; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            case (i)
                12: v = et[15:8];
                13: v = et[7:0];
                14: v = tci;
                16: v = et2[15:8];
                17: v = et2[7:0];
                18: v = tci2;
                default: ;
            endcase
            frm.push_back(v);
        end
    endtask

    // kind: 0 untagged/short, 1 single tag, 2 stacked tags.
    task automatic classify(output int kind, output int pcp);
        int         n;
        logic [7:0] t;
        logic [15:0] et, et2;
        n    = frm.size();
        kind = 0;
        pcp  = 0;
        if (n >= 15) begin
            et = {frm[12], frm[13]};
            if (et == 16'h8100 || et == 16'h88A8 || et == 16'h9100) begin
                t    = frm[14];
                kind = 1;
                pcp  = int'(t[7:5]);
                if (et != 16'h8100 && n >= 19) begin
                    et2 = {frm[16], frm[17]};
                    if (et2 == 16'h8100) begin
                        t    = frm[18];
                        kind = 2;
                        pcp  = int'(t[7:5]);
                    end
                end
            end
        end
    endtask

    task automatic send_frame();
        int            n, nbeats, kind, pcp;
        logic [TW-1:0] dest;
        beat_t         bt [$];
        bit            hs, ok, all_ok;
        n      = frm.size();
        nbeats = (n + DB - 1) / DB;
        classify(kind, pcp);
        case (kind)
            1:       begin dest = map_m[3'(pcp)]; n_tag_m++;   end
            2:       begin dest = map_m[3'(pcp)]; n_qinq_m++;  end
            default: begin dest = dflt_m;         n_untag_m++; end
        endcase
        for (int k = 0; k < nbeats; k++) begin
            beat_t x;
            x = '0;
            for (int l = 0; l < DB; l++) begin
                if (k * DB + l < n) begin
                    x.data = x.data | ((8*DB)'(frm[k*DB+l]) << (8 * l));
                    x.keep = x.keep | (DB'(1) << l);
                end
            end
            x.last = (k == nbeats - 1);
            x.user = 2'($urandom);
            x.dest = dest;
            bt.push_back(x);
            exp_q.push_back(x);
        end
        all_ok = 1'b1;
        for (int k = 0; k < nbeats && all_ok; k++) begin
            if ($urandom_range(3) == 0) begin
                s_if.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = bt[k].data;
            s_if.tkeep  = bt[k].keep;
            s_if.tlast  = bt[k].last;
            s_if.tuser  = bt[k].user;
            ok = 1'b0;
            for (int t = 0; t < 2000 && !ok; t++) begin
                @(negedge clk);
                hs = s_if.tready;
                @(posedge clk);
                #1;
                ok = hs;
            end
            all_ok = ok;
        end
        check_eq("s_accept", 64'(all_ok), 64'd1);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 4000 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check_eq("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_counters();
        check_eq("cnt_tagged", 64'(cnt_tagged), 64'(n_tag_m));
        check_eq("cnt_qinq", 64'(cnt_qinq), 64'(n_qinq_m));
        check_eq("cnt_untagged", 64'(cnt_untagged), 64'(n_untag_m));
    endtask

    // Downstream ready pattern: 0 always ready, 1 random 50%, otherwise held low.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = 1'($urandom_range(1));
            default: m_if.tready = 1'b0;
        endcase
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstn && m_if.tvalid && m_if.tready) begin
            bit    have;
            beat_t e;
            have = (exp_q.size() != 0);
            check_eq("beat_expected", 64'(have), 64'd1);
            if (have) begin
                e = exp_q.pop_front();
                check_eq("tdata", 64'(m_if.tdata), 64'(e.data));
                check_eq("tkeep", 64'(m_if.tkeep), 64'(e.keep));
                check_eq("tlast", 64'(m_if.tlast), 64'(e.last));
                check_eq("tuser", 64'(m_if.tuser), 64'(e.user));
                check_eq("tdest", 64'(m_if.tdest), 64'(e.dest));
            end
        end
    end

    initial begin
        int          len, sel;
        logic [15:0] et, et2;
        n_checks  = 0;
        n_errors  = 0;
        n_tag_m   = 0;
        n_qinq_m  = 0;
        n_untag_m = 0;
        rdy_mode  = 0;
        rstn        = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = '0;
        s_if.tdest  = '0;
        for (int i = 0; i < 8; i++) map_m[i] = 3'(7 - i);
        dflt_m = 3'd1;
        apply_map();

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check_eq("rst_tdest", 64'(m_if.tdest), 64'd0);
        check_eq("rst_s_tready", 64'(s_if.tready), 64'd1);
        check_counters();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single tag, PCP 5.
        make_frame(64, 16'h8100, 8'hA0, 16'h0800, 8'h45);
        send_frame();
        wait_drain();
        check_counters();

        // Untagged IPv4.
        make_frame(64, 16'h0800, 8'h45, 16'h0000, 8'h00);
        send_frame();
        wait_drain();
        check_counters();

        // QinQ, outer PCP 2, inner PCP 6.
        make_frame(64, 16'h88A8, 8'h40, 16'h8100, 8'hC0);
        send_frame();
        wait_drain();
        check_counters();

        // 10-byte frame: decided on tlast, replayed, no input taken while replaying.
        make_frame(10, 16'h8100, 8'hE0, 16'h8100, 8'hE0);
        send_frame();
        @(negedge clk);
        check_eq("short_first_out_valid", 64'(m_if.tvalid), 64'd1);
        check_eq("short_flush_no_input", 64'(s_if.tready), 64'd0);
        repeat (2) @(negedge clk);
        check_eq("short_flush_no_input2", 64'(s_if.tready), 64'd0);
        @(negedge clk);
        check_eq("short_back_to_buffer", 64'(s_if.tready), 64'd1);
        check_eq("short_out_idle", 64'(m_if.tvalid), 64'd0);
        wait_drain();
        check_counters();

        // 61-byte tagged then untagged, back-to-back, random backpressure.
        rdy_mode = 1;
        make_frame(61, 16'h8100, 8'h60, 16'h0800, 8'h45);
        send_frame();
        make_frame(61, 16'h86DD, 8'h60, 16'h0000, 8'h00);
        send_frame();
        wait_drain();
        check_counters();

        // Reset while a tagged frame sits in the replay buffer.
        rdy_mode = 2;
        make_frame(18, 16'h8100, 8'h20, 16'h0800, 8'h45);
        send_frame();
        @(negedge clk);
        check_eq("flush_held", 64'(m_if.tvalid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("rst_async_tvalid", 64'(m_if.tvalid), 64'd0);
        check_eq("rst_async_tdest", 64'(m_if.tdest), 64'd0);
        exp_q.delete();
        n_tag_m   = 0;
        n_qinq_m  = 0;
        n_untag_m = 0;
        check_counters();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn     = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        make_frame(40, 16'h9100, 8'h80, 16'h8100, 8'h20);
        send_frame();
        wait_drain();
        check_counters();

        // Random frames, random maps (changed between frames), random backpressure.
        for (int f = 0; f < 150; f++) begin
            rdy_mode = int'($urandom_range(1));
            for (int i = 0; i < 8; i++) map_m[i] = 3'($urandom);
            dflt_m = 3'($urandom);
            apply_map();
            len = ($urandom_range(1) == 1) ? int'($urandom_range(24, 1))
                                           : int'($urandom_range(90, 25));
            sel = int'($urandom_range(3));
            et  = (sel == 0) ? 16'($urandom) : (sel == 1) ? 16'h8100 :
                  (sel == 2) ? 16'h88A8 : 16'h9100;
            et2 = ($urandom_range(9) < 7) ? 16'h8100 : 16'($urandom);
            make_frame(len, et, 8'($urandom), et2, 8'($urandom));
            send_frame();
        end
        wait_drain();
        check_counters();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
